instr_fetch_unit: RTL and testbench

//  Fetch stage downstream of the program counter: takes current PC, issues in-order requests on a
//  req/gnt/rvalid instruction-memory port, buffers returned words with their PC, and hands
//  {pc, instr} to decode over valid/ready. Drives the PC's write enable (advance on grant, load on flush).

---
 rtl/ifetch_pkg.sv | 17 +
 rtl/instr_fetch_unit_fifo.sv | 52 +++++
 rtl/instr_fetch_unit.sv | 130 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] IFETCH_NOP = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Synchronous FIFO with a synchronous clear. Used as the instruction buffer and as the PC-tag queue.
module fetch_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [31:0]
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: in-order req/gnt/rvalid requests, buffered {pc, instr} handed to decode.
// Define IFETCH_STATS_EN to add the fetched/stall/flush statistics counters.
module instr_fetch_unit
  import ifetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] pc_i,
  output logic                  pc_write_o,
  input  logic                  flush_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] instr_pc_o,
  input  logic                  instr_ready_i,
  output fetch_state_e          dbg_state_o
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0]           stat_fetched_o,
  output logic [31:0]           stat_stall_o,
  output logic [31:0]           stat_flush_o
`endif
);
  // Handshakes: imem request transfers when req & gnt (req and addr held until then);
  // decode transfer happens when instr_valid & instr_ready; both sampled on the rising clk edge.
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  fetch_state_e          state, state_next;
  logic [CW-1:0]         outstanding, discard_cnt, drain_left;
  logic [CW-1:0]         fifo_count, tag_count;
  logic [CW:0]           credit_used;
  logic                  grant, rv_ok, keep, instr_pop;
  logic                  instr_full, instr_empty, tag_full, tag_empty;
  logic [DATA_WIDTH-1:0] tag_head;
  entry_t                head;

  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
  // Counting buffered plus in-flight words guarantees every response finds a FIFO slot.
  assign imem_req_o  = (state == FETCH) && !flush_i && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_addr_o = pc_i;
  assign grant       = imem_req_o && imem_gnt_i;
  assign pc_write_o  = grant || flush_i;
  assign rv_ok       = imem_rvalid_i && (outstanding != '0);
  assign keep        = rv_ok && (discard_cnt == '0) && !flush_i;
  assign drain_left  = outstanding - CW'(rv_ok);
  assign instr_pop   = instr_valid_o && instr_ready_i && !flush_i;

  assign instr_valid_o = !instr_empty;
  assign instr_o       = head.instr;
  assign instr_pc_o    = head.pc;
  assign dbg_state_o   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      state       <= state_next;
      outstanding <= outstanding + CW'(grant) - CW'(rv_ok);
      if (flush_i)                              discard_cnt <= drain_left;
      else if (rv_ok && discard_cnt != '0)      discard_cnt <= discard_cnt - 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = (flush_i && drain_left != '0) ? DRAIN : FETCH;
      FETCH:   if (flush_i && drain_left != '0) state_next = DRAIN;
      DRAIN: begin
        if (flush_i && drain_left != '0) state_next = DRAIN;
        else if (discard_cnt == '0)      state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(logic [DATA_WIDTH-1:0])) u_tag_q (
    .clk(clk), .rst_n(rst_n), .clear(flush_i),
    .push(grant), .push_data(pc_i),
    .pop(keep), .pop_data(tag_head),
    .full(tag_full), .empty(tag_empty), .count(tag_count)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(entry_t)) u_instr_q (
    .clk(clk), .rst_n(rst_n), .clear(flush_i),
    .push(keep), .push_data('{pc: tag_head, instr: imem_rdata_i}),
    .pop(instr_pop), .pop_data(head),
    .full(instr_full), .empty(instr_empty), .count(fifo_count)
  );

  // Tags exist only for responses that will be kept.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(imem_rvalid_i && outstanding == '0));
      assert (!(grant && tag_full));
      assert (!(keep && tag_empty));
      assert (!(keep && instr_full && !instr_pop));
      assert (tag_count == outstanding - discard_cnt);
    end
  end

`ifdef IFETCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fetched_o <= '0;
      stat_stall_o   <= '0;
      stat_flush_o   <= '0;
    end else begin
      stat_fetched_o <= stat_fetched_o + 32'(keep);
      stat_stall_o   <= stat_stall_o + 32'(imem_req_o && !imem_gnt_i);
      stat_flush_o   <= stat_flush_o + 32'(flush_i);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: bench acts as PC and memory; scoreboard checks decode output.
module tb_instr_fetch_unit;
  import ifetch_pkg::*;

  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  pc_i = '0;
  logic         pc_write;
  logic         flush = 1'b0;
  logic         req;
  logic [31:0]  addr;
  logic         gnt = 1'b0;
  logic         rvalid = 1'b0;
  logic [31:0]  rdata = '0;
  logic         instr_valid;
  logic [31:0]  instr;
  logic [31:0]  instr_pc;
  logic         ready = 1'b0;
  fetch_state_e dbg_state;
`ifdef IFETCH_STATS_EN
  logic [31:0]  stat_fetched, stat_stall, stat_flush;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .pc_i(pc_i), .pc_write_o(pc_write), .flush_i(flush),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt), .imem_rvalid_i(rvalid),
    .imem_rdata_i(rdata), .instr_valid_o(instr_valid), .instr_o(instr), .instr_pc_o(instr_pc),
    .instr_ready_i(ready), .dbg_state_o(dbg_state)
`ifdef IFETCH_STATS_EN
    , .stat_fetched_o(stat_fetched), .stat_stall_o(stat_stall), .stat_flush_o(stat_flush)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    bit          live;
  } pend_t;

  pend_t        pend_q[$];
  logic [63:0]  exp_q[$];
  fetch_state_e st;
  logic [31:0]  pc_model, flush_target, last_pop_pc;
  logic [31:0]  m_fetched, m_stall, m_flush;
  bit           resp_en;
  int           n_checks = 0, n_fails = 0, n_grants = 0, n_pops = 0;

  function automatic logic [31:0] instr_of(logic [31:0] a);
    return {a[23:0], 8'h13} ^ 32'h5A00_0000;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend_q.delete();
    exp_q.delete();
    st = IDLE;
    pc_model = '0;
    m_fetched = '0;
    m_stall = '0;
    m_flush = '0;
  endtask

  // One clock cycle: drive memory response, check outputs against the model, advance the model.
  task automatic tick();
    int          n_out, n_fifo, n_dead;
    bit          exp_req, grant, pop;
    logic [63:0] e;
    pend_t       p;
    if (resp_en && pend_q.size() > 0) begin
      rvalid = 1'b1;
      rdata  = instr_of(pend_q[0].pc);
    end else begin
      rvalid = 1'b0;
      rdata  = '0;
    end
    #1;
    n_out  = pend_q.size();
    n_fifo = exp_q.size();
    n_dead = 0;
    foreach (pend_q[i]) if (!pend_q[i].live) n_dead++;
    exp_req = (st == FETCH) && !flush && ((n_out + n_fifo) < DEPTH);
    grant   = exp_req && gnt;
    check("state", dbg_state, st);
    check("req", req, exp_req);
    check("addr", addr, pc_model);
    check("pc_write", pc_write, grant || flush);
    check("instr_valid", instr_valid, n_fifo != 0);
    pop = (n_fifo != 0) && ready && !flush;
    if (pop) begin
      e = exp_q.pop_front();
      check("instr", instr, e[31:0]);
      check("instr_pc", instr_pc, e[63:32]);
      last_pop_pc = e[63:32];
      n_pops++;
    end
    if (rvalid) begin
      p = pend_q.pop_front();
      if (p.live && !flush) begin
        exp_q.push_back({p.pc, instr_of(p.pc)});
        m_fetched++;
      end
    end
    if (flush) begin
      exp_q.delete();
      foreach (pend_q[i]) pend_q[i].live = 1'b0;
      m_flush++;
    end
    if (grant) begin
      pend_q.push_back('{pc: pc_model, live: 1'b1});
      n_grants++;
    end
    if (exp_req && !gnt) m_stall++;
    case (st)
      IDLE:  st = (flush && (n_out - int'(rvalid)) > 0) ? DRAIN : FETCH;
      FETCH: if (flush && (n_out - int'(rvalid)) > 0) st = DRAIN;
      default: begin
        if (flush && (n_out - int'(rvalid)) > 0) st = DRAIN;
        else if (n_dead == 0)                    st = FETCH;
      end
    endcase
    if (flush)      pc_model = flush_target;
    else if (grant) pc_model = pc_model + 32'd4;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    pc_i  = pc_model;
  endtask

  task automatic drain_all(string tag);
    gnt = 1'b0; ready = 1'b1; resp_en = 1'b1;
    for (int i = 0; i < 30 && (pend_q.size() > 0 || exp_q.size() > 0); i++) tick();
    check(tag, pend_q.size() + exp_q.size(), 0);
  endtask

  int          g0, p0;
  logic [31:0] a0;
`ifdef IFETCH_STATS_EN
  logic [31:0] s0;
`endif

  initial begin
    model_reset();
    resp_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", instr_valid, 0);
    check("rst_req", req, 0);
    check("rst_pc_write", pc_write, 0);
    check("rst_instr", {instr_pc, instr}, 0);
    check("rst_state", dbg_state, IDLE);
`ifdef IFETCH_STATS_EN
    check("rst_stats", {stat_fetched, stat_stall, stat_flush}, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // 1: streaming fetch of 0x0, 0x4, 0x8 with decode always ready
    gnt = 1'b1; ready = 1'b1; resp_en = 1'b1;
    for (int i = 0; i < 40 && n_pops < 3; i++) begin
      if (n_grants >= 3) gnt = 1'b0;
      tick();
    end
    check("t1_pops", n_pops, 3);
    check("t1_last_pc", last_pop_pc, 32'h8);
    drain_all("t1_drain");

    // 2: decode stalled; credit limit holds issue at two
    gnt = 1'b1; ready = 1'b0; resp_en = 1'b1;
    g0 = n_grants;
    repeat (6) tick();
    check("t2_grants", n_grants - g0, 2);
    #1;
    check("t2_req_held", req, 0);
    check("t2_pc_write", pc_write, 0);
    drain_all("t2_drain");

    // 3: grant withheld for three cycles
    gnt = 1'b0; ready = 1'b1;
    a0 = pc_model;
`ifdef IFETCH_STATS_EN
    s0 = stat_stall;
`endif
    repeat (3) begin
      #1;
      check("t3_req", req, 1);
      check("t3_addr", addr, a0);
      check("t3_pc_write", pc_write, 0);
      tick();
    end
`ifdef IFETCH_STATS_EN
    check("t3_stall", stat_stall - s0, 3);
`endif
    gnt = 1'b1;
    tick();
    drain_all("t3_drain");

    // 4: flush with two requests in flight; both responses dropped
    gnt = 1'b1; ready = 1'b1; resp_en = 1'b0;
    for (int i = 0; i < 10 && pend_q.size() < 2; i++) tick();
    check("t4_outstanding", pend_q.size(), 2);
    flush = 1'b1; flush_target = 32'h40;
    tick();
    #1;
    check("t4_drain", dbg_state, DRAIN);
    resp_en = 1'b1;
    p0 = n_pops;
    for (int i = 0; i < 30 && n_pops == p0; i++) tick();
    check("t4_popped", n_pops - p0, 1);
    check("t4_first_pc", last_pop_pc, 32'h40);
    drain_all("t4_end");

    // 5: flush collides with rvalid and with a decode pop
    gnt = 1'b1; ready = 1'b0; resp_en = 1'b1;
    for (int i = 0; i < 10 && !(pend_q.size() == 1 && exp_q.size() == 1); i++) tick();
    check("t5_setup", {pend_q.size(), exp_q.size()}, {32'd1, 32'd1});
    flush = 1'b1; flush_target = 32'h80; ready = 1'b1;
    p0 = n_pops;
    tick();
    #1;
    check("t5_no_pop", n_pops - p0, 0);
    check("t5_valid", instr_valid, 0);
    check("t5_state", dbg_state, FETCH);
    p0 = n_pops;
    for (int i = 0; i < 20 && n_pops == p0; i++) tick();
    check("t5_next_pc", last_pop_pc, 32'h80);
    drain_all("t5_end");

    // 6: asynchronous reset with two requests outstanding
    gnt = 1'b1; ready = 1'b1; resp_en = 1'b0;
    for (int i = 0; i < 10 && pend_q.size() < 2; i++) tick();
    check("t6_outstanding", pend_q.size(), 2);
    #2 rst_n = 1'b0;
    gnt = 1'b0; rvalid = 1'b0;
    #1;
    check("t6_valid", instr_valid, 0);
    check("t6_req", req, 0);
    check("t6_pc_write", pc_write, 0);
    check("t6_state", dbg_state, IDLE);
    model_reset();
    pc_i = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    gnt = 1'b1; resp_en = 1'b1;
    p0 = n_pops;
    for (int i = 0; i < 20 && n_pops == p0; i++) tick();
    check("t6_first_pc", last_pop_pc, 32'h0);
    for (int i = 0; i < 20 && n_pops == p0 + 1; i++) tick();
    check("t6_second_pc", last_pop_pc, 32'h4);
    drain_all("t6_end");

`ifdef IFETCH_STATS_EN
    check("stat_fetched", stat_fetched, m_fetched);
    check("stat_stall", stat_stall, m_stall);
    check("stat_flush", stat_flush, m_flush);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
